// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// time-multiplexed display bus with active-low anode select.
module bcd_display_scanner #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  digit,
  output logic [3:0]  anode
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state;
  logic [15:0] acc;
  logic [15:0] adj;
  logic [15:0] disp;
  logic [13:0] bin;
  logic [3:0]  bit_cnt;
  logic [13:0] value_sat;
  logic        value_big;
  logic        unused_adj_msb;

  assign value_big = (value_in > 14'd9999);
  assign value_sat = value_big ? 14'd9999 : value_in;

  // Double-dabble correction applied before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (acc[gi*4 +: 4] >= 4'd5) ? acc[gi*4 +: 4] + 4'd3
                                                        : acc[gi*4 +: 4];
    end
  endgenerate

  // Inputs are capped at 9999, so the top BCD bit never shifts out.
  assign unused_adj_msb = adj[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      bin      <= '0;
      bit_cnt  <= '0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin      <= value_sat;
            acc      <= '0;
            bit_cnt  <= '0;
            overflow <= value_big;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= {adj[14:0], bin[13]};
          bin     <= {bin[12:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd13) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          disp  <= acc;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;

  // Scanning is free-running and unaffected by conversions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    case (idx)
      2'd0:    anode = 4'b1110;
      2'd1:    anode = 4'b1101;
      2'd2:    anode = 4'b1011;
      default: anode = 4'b0111;
    endcase
  end

  // A position is blank when it and every more significant nibble are zero.
  logic [3:0] blank;
  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = BLANK_LEADING && (disp[15:gi*4] == '0);
    end
  endgenerate

  always_comb begin
    digit = disp[{idx, 2'b00} +: 4];
    if (blank[idx]) begin
      digit = 4'hF;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus pushes hand-computed displays, a monitor pops them
// on each busy fall and checks the scanned bus continuously.
module tb_bcd_display_scanner;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] value_in = '0;
  logic        busy0, ovf0, busy1, ovf1;
  logic [3:0]  digit0, anode0, digit1, anode1;

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut_blank (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .busy(busy0), .overflow(ovf0), .digit(digit0), .anode(anode0));

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_zeros (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .busy(busy1), .overflow(ovf1), .digit(digit1), .anode(anode1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ovf;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scan position: counts RD cycles per digit from reset release.
  int m_cnt, m_idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == RD - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  logic [15:0] cur0, cur1;
  logic [3:0]  exp_an;
  logic        prev_busy;
  int          bcnt;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      cur0      = 16'hFFF0;
      cur1      = 16'h0000;
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (prev_busy && !busy0) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          e = q.pop_front();
          cur0 = e.d0;
          cur1 = e.d1;
          chk("overflow", int'(ovf0), int'(e.ovf));
          chk("overflow_noblank", int'(ovf1), int'(e.ovf));
          chk("busy_cycles", bcnt, 15);
        end
        bcnt = 0;
      end
      if (busy0) bcnt++;
      exp_an = ~(4'b0001 << m_idx);
      chk("anode", int'(anode0), int'(exp_an));
      chk("digit_blank", int'(digit0), int'(cur0[m_idx*4 +: 4]));
      chk("digit_noblank", int'(digit1), int'(cur1[m_idx*4 +: 4]));
      prev_busy = busy0;
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy0 && q.size() == 0) break;
      @(negedge clk);
    end
    if (i == 40) chk("commit_timeout", 0, 1);
    repeat (16) @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] d0, input logic [15:0] d1, input logic ovf);
    exp_t x;
    x.d0 = d0;
    x.d1 = d1;
    x.ovf = ovf;
    q.push_back(x);
  endtask

  task automatic do_load(input logic [13:0] v, input logic [15:0] d0,
                         input logic [15:0] d1, input logic ovf);
    @(negedge clk);
    value_in = v;
    load = 1'b1;
    push_exp(d0, d1, ovf);
    @(negedge clk);
    load = 1'b0;
    $display("[TB] load %0d expect %h / %h ovf=%0b", v, d0, d1, ovf);
    wait_idle();
  endtask

  // Second load lands on the cycle after acceptance and must be dropped.
  task automatic do_reject(input logic [13:0] v, input logic [13:0] v2,
                           input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clk);
    value_in = v;
    load = 1'b1;
    push_exp(d0, d1, 1'b0);
    @(negedge clk);
    value_in = v2;
    @(negedge clk);
    load = 1'b0;
    $display("[TB] load %0d then ignored %0d expect %h", v, v2, d0);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_overflow", int'(ovf0), 0);
    chk("rst_anode", int'(anode0), 4'b1110);
    chk("rst_digit", int'(digit0), 0);
    chk("rst_digit_noblank", int'(digit1), 0);
    repeat (17) @(negedge clk);

    do_load(14'd1234,  16'h1234, 16'h1234, 1'b0);
    do_load(14'd12000, 16'h9999, 16'h9999, 1'b1);
    do_load(14'd7,     16'hFFF7, 16'h0007, 1'b0);
    do_load(14'd405,   16'hF405, 16'h0405, 1'b0);
    do_load(14'd0,     16'hFFF0, 16'h0000, 1'b0);
    do_reject(14'd1111, 14'd2222,  16'h1111, 16'h1111);
    do_reject(14'd3000, 14'd16000, 16'h3000, 16'h3000);

    // Reset in the middle of a conversion.
    @(negedge clk);
    value_in = 14'd3333;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_overflow", int'(ovf0), 0);
    chk("abort_anode", int'(anode0), 4'b1110);
    chk("abort_digit", int'(digit0), 0);
    $display("[TB] reset during conversion of 3333");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    chk("abort_no_commit", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
